program_rom_loader: RTL and testbench
=====================================

Name: program_rom_loader

Overview:
- Write-side counterpart of the split program ROM fetch path. The fetch path reads a 32-bit instruction as a LOW half (bits 15:0) and a HIGH half (bits 31:16).
- This block accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Each word is driven as one write strobe carrying separate LOW and HIGH 16-bit halves at a word address, filling BEGIN_ADDR..END_ADDR.
- Sits between the host/boot link and the program memory write ports. Busy holds the processor off the ROM while loading.

Parameters:
- ROM_ADDR_BITS, 4, width of the word address.
- BEGIN_ADDR, 0, first word address written.
- END_ADDR, 15, last legal word address. Requires BEGIN_ADDR <= END_ADDR < 2**ROM_ADDR_BITS.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- Start  in  1  one-cycle load request.
- NumWords  in  ROM_ADDR_BITS+1  words to load; sampled on accepted Start.
- ByteIn  in  8  stream data byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- WriteEnable  out  1  one-cycle write strobe to both LOW and HIGH memories.
- WriteAddress  out  ROM_ADDR_BITS  word address of the write.
- WriteDataLow  out  16  instruction bits 15:0.
- WriteDataHigh  out  16  instruction bits 31:16.
- Busy  out  1  load in progress.
- Done  out  1  load finished; held until next accepted Start or RST.
- Overflow  out  1  NumWords exceeded capacity; valid while Done.
- ChecksumError  out  1  see Optional Feature; valid while Done.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-load): state=IDLE. ByteReady, WriteEnable, Busy, Done, Overflow and ChecksumError are all 0. WriteAddress=BEGIN_ADDR. WriteDataLow/High=0. Byte index, word counter and checksum accumulator are cleared. A partially assembled word is discarded and not written.
- FSM states: IDLE, COLLECT, WRITE, (CHECK), DONE.
- IDLE, or DONE with Start=1:
  - Latch NumWords.
  - Set address=BEGIN_ADDR, byte index=0.
  - Clear Done, Overflow and ChecksumError.
  - Go to COLLECT, or directly to DONE if NumWords=0.
- Start is ignored in COLLECT, WRITE and CHECK.
- Capacity is CAP = END_ADDR-BEGIN_ADDR+1. If NumWords > CAP, load CAP words and set Overflow=1 on entering DONE. The excess stream bytes are not consumed.
- COLLECT:
  - ByteReady=1.
  - A byte is accepted when ByteValid && ByteReady at the edge.
  - Byte k (k=0..3) goes to word bits [8k+7:8k], little-endian.
  - ByteValid low stalls with no state change.
  - On acceptance of byte 3, go to WRITE.
- WRITE (exactly one cycle):
  - ByteReady=0, WriteEnable=1.
  - WriteAddress = current address; WriteDataLow = word[15:0]; WriteDataHigh = word[31:16].
  - Latency: the 4th byte is accepted at edge N; WriteEnable is high during cycle N+1.
  - At the end of WRITE: address+1, words written+1, byte index=0.
  - If words written == min(NumWords,CAP), go to CHECK (macro on) or DONE. Otherwise go to COLLECT.
  - The address never increments past END_ADDR, so there is no wrap.
- DONE: Busy=0, Done=1, ByteReady=0, WriteEnable=0.
- Busy=1 in COLLECT, WRITE and CHECK.
- WriteEnable is never high outside WRITE. WriteAddress and WriteData hold their last values otherwise.

Optional Feature:
- Macro: PROGRAM_ROM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator sums every accepted data byte (mod 256).
  - After the last WRITE, the FSM enters CHECK with ByteReady=1 and accepts one checksum byte.
  - The check passes when (accumulator + checksum byte) mod 256 == 0.
  - A pass sets ChecksumError=0, a fail sets it to 1, and either way the FSM goes to DONE.
  - On Overflow, the checksum covers only the CAP words loaded. The next stream byte is treated as the checksum.
  - NumWords=0 still goes through CHECK, with accumulator 0.
- Undefined: no CHECK state, no accumulator logic, and ChecksumError is tied to 0.

Test Plan:
- Basic load, macro off: RST, then Start with NumWords=2, then bytes 78 56 34 12 EF BE AD DE.
  - Required: write addr0 Low=5678 High=1234, then addr1 Low=BEEF High=DEAD.
  - WriteEnable is high exactly 2 cycles, each one cycle after the 4th byte.
  - Then Done=1, Busy=0, Overflow=0.
- Handshake stall: the same stream with ByteValid toggled 1/0 on alternate cycles.
  - Required: identical writes.
  - ByteReady=0 in WRITE cycles; no byte is lost or duplicated.
- Overflow, defaults (CAP=16): Start with NumWords=20 and 80 bytes offered.
  - Required: 16 writes, addr 0..15; Done=1, Overflow=1.
  - Bytes 65..80 are not accepted.
  - No write occurs at addr 0 after 15.
- Reset mid-operation: Start with NumWords=3, then 6 bytes (one full word, two bytes into the second), then RST high for 1 cycle.
  - Required: only the addr0 write occurred.
  - After RST: all outputs 0, WriteAddress=BEGIN_ADDR.
  - A fresh load of NumWords=1 writes at addr0.
- Zero and ignored Start: Start with NumWords=0.
  - Required: Done=1 next cycle, no WriteEnable.
  - Then Start with NumWords=1 and a second Start pulse mid-COLLECT: the second Start is ignored and exactly one write occurs.
- Checksum, macro on: NumWords=1, bytes 01 02 03 04, then checksum F6.
  - Required: ChecksumError=0, Done=1.
  - Repeat with checksum F5: ChecksumError=1, Done=1, and the word is still written at addr0.

Source files
------------

// File: rtl/program_rom_loader.sv
// rtl/program_rom_loader.sv - byte stream to split LOW/HIGH 32-bit program ROM word loader
// Optional trailing checksum byte: define PROGRAM_ROM_LOADER_CHECKSUM_EN.
module program_rom_loader #(
  parameter int ROM_ADDR_BITS = 4,
  parameter int BEGIN_ADDR    = 0,
  parameter int END_ADDR      = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [ROM_ADDR_BITS:0]   NumWords,
  input  logic [7:0]               ByteIn,
  input  logic                     ByteValid,
  output logic                     ByteReady,
  output logic                     WriteEnable,
  output logic [ROM_ADDR_BITS-1:0] WriteAddress,
  output logic [15:0]              WriteDataLow,
  output logic [15:0]              WriteDataHigh,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Overflow,
  output logic                     ChecksumError
);

  localparam int AW = ROM_ADDR_BITS;
  localparam int CW = ROM_ADDR_BITS + 1;
  // Number of words that fit between BEGIN_ADDR and END_ADDR inclusive.
  localparam logic [CW-1:0] CAP        = CW'(END_ADDR - BEGIN_ADDR + 1);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(BEGIN_ADDR);

`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   limit_q, limit_d;        // min(NumWords, CAP)
  logic            ovf_pend_q, ovf_pend_d;  // NumWords exceeded CAP, reported at DONE
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;        // words written so far
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     part_q, part_d;          // bytes 0..2 of the word being assembled
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]     wr_lo_q, wr_lo_d;
  logic [15:0]     wr_hi_q, wr_hi_d;
  logic            overflow_q, overflow_d;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
  logic            cerr_q, cerr_d;
`endif

  logic            accept;
  logic [CW-1:0]   count_inc;

  // Output decode from the registered state; write data/address are registered.
  always_comb begin
    ByteReady     = (state_q == COLLECT);
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    ByteReady     = (state_q == COLLECT) || (state_q == CHECK);
    Busy          = (state_q == COLLECT) || (state_q == WRITE) || (state_q == CHECK);
    ChecksumError = cerr_q;
`else
    Busy          = (state_q == COLLECT) || (state_q == WRITE);
    ChecksumError = 1'b0;
`endif
    WriteEnable   = (state_q == WRITE);
    Done          = (state_q == DONE);
    Overflow      = overflow_q;
    WriteAddress  = wr_addr_q;
    WriteDataLow  = wr_lo_q;
    WriteDataHigh = wr_hi_q;
  end

  // Next-state logic: byte assembly, write sequencing and load bookkeeping.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    ovf_pend_d = ovf_pend_q;
    addr_d     = addr_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    part_d     = part_q;
    wr_addr_d  = wr_addr_q;
    wr_lo_d    = wr_lo_q;
    wr_hi_d    = wr_hi_q;
    overflow_d = overflow_q;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
    cerr_d     = cerr_q;
`endif
    accept     = ByteValid && ByteReady;
    count_inc  = count_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          limit_d    = (NumWords > CAP) ? CAP : NumWords;
          ovf_pend_d = (NumWords > CAP);
          addr_d     = FIRST_ADDR;
          count_d    = '0;
          byte_idx_d = 2'd0;
          overflow_d = 1'b0;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
          acc_d      = 8'h00;
          cerr_d     = 1'b0;
          // An empty load still consumes and verifies the checksum byte.
          state_d    = (NumWords == '0) ? CHECK : COLLECT;
`else
          state_d    = (NumWords == '0) ? DONE : COLLECT;
`endif
        end
      end

      COLLECT: begin
        if (accept) begin
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
          acc_d = acc_q + ByteIn;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: part_d[7:0]   = ByteIn;
            2'd1: part_d[15:8]  = ByteIn;
            2'd2: part_d[23:16] = ByteIn;
            default: begin
              // Byte 3 completes the word; present it straight to the write registers.
              wr_addr_d = addr_q;
              wr_lo_d   = part_q[15:0];
              wr_hi_d   = {ByteIn, part_q[23:16]};
              state_d   = WRITE;
            end
          endcase
        end
      end

      WRITE: begin
        count_d    = count_inc;
        byte_idx_d = 2'd0;
        if (count_inc == limit_q) begin
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
          state_d    = CHECK;
`else
          overflow_d = ovf_pend_q;
          state_d    = DONE;
`endif
        end else begin
          // Only advance when another word follows, so END_ADDR never wraps.
          addr_d  = addr_q + 1'b1;
          state_d = COLLECT;
        end
      end

`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          cerr_d     = (8'(acc_q + ByteIn) != 8'h00);
          overflow_d = ovf_pend_q;
          state_d    = DONE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      ovf_pend_q <= 1'b0;
      addr_q     <= FIRST_ADDR;
      count_q    <= '0;
      byte_idx_q <= 2'd0;
      part_q     <= '0;
      wr_addr_q  <= FIRST_ADDR;
      wr_lo_q    <= '0;
      wr_hi_q    <= '0;
      overflow_q <= 1'b0;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
      acc_q      <= 8'h00;
      cerr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      ovf_pend_q <= ovf_pend_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      part_q     <= part_d;
      wr_addr_q  <= wr_addr_d;
      wr_lo_q    <= wr_lo_d;
      wr_hi_q    <= wr_hi_d;
      overflow_q <= overflow_d;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
      acc_q      <= acc_d;
      cerr_q     <= cerr_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_rom_loader.sv
// tb/tb_program_rom_loader.sv - directed self-checking bench for program_rom_loader
`timescale 1ns/1ps
module tb_program_rom_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [4:0]  NumWords;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [3:0]  WriteAddress;
  logic [15:0] WriteDataLow;
  logic [15:0] WriteDataHigh;
  logic        Busy;
  logic        Done;
  logic        Overflow;
  logic        ChecksumError;

  program_rom_loader #(.ROM_ADDR_BITS(4), .BEGIN_ADDR(0), .END_ADDR(15)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .NumWords(NumWords),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteDataLow(WriteDataLow), .WriteDataHigh(WriteDataHigh),
    .Busy(Busy), .Done(Done), .Overflow(Overflow), .ChecksumError(ChecksumError)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_in_write = 0;
  logic [3:0]  wa_log[$];
  logic [15:0] wl_log[$];
  logic [15:0] wh_log[$];
  int          wc_log[$];
  int          ac_log[$];

  // Record every write strobe and every byte handshake, sampled mid-cycle.
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      if (WriteEnable) begin
        wa_log.push_back(WriteAddress);
        wl_log.push_back(WriteDataLow);
        wh_log.push_back(WriteDataHigh);
        wc_log.push_back(cyc);
        if (ByteReady) rdy_in_write++;
      end
      if (ByteValid && ByteReady) ac_log.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs;
    wa_log.delete(); wl_log.delete(); wh_log.delete();
    wc_log.delete(); ac_log.delete();
    rdy_in_write = 0;
  endtask

  task automatic do_reset;
    RST = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00; NumWords = '0;
    tick; tick;
    RST = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] n);
    Start = 1'b1; NumWords = n;
    tick;
    Start = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] b[$], input bit stall, input int budget,
                             output int n_acc);
    int i = 0;
    bit ph = 1'b1;
    logic acc;
    n_acc = 0;
    for (int k = 0; k < budget && i < b.size(); k++) begin
      ByteIn = b[i];
      ByteValid = stall ? ph : 1'b1;
      ph = ~ph;
      @(negedge CLK);
      acc = ByteValid && ByteReady;
      tick;
      if (acc) begin i++; n_acc++; end
    end
    ByteValid = 1'b0;
  endtask

  function automatic logic [7:0] cks_of(input logic [7:0] b[$]);
    logic [7:0] s = 8'h00;
    foreach (b[i]) s = s + b[i];
    return 8'h00 - s;
  endfunction

  task automatic finish_load(input logic [7:0] cb);
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    logic [7:0] q[$];
    int n;
    q.push_back(cb);
    send_stream(q, 1'b0, 20, n);
`endif
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (Done === 1'b1) seen = 1'b1;
      tick;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL %s_done_timeout got Done=%b want 1", name, Done); end
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge CLK);
    n_vec++; if (ByteReady !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ByteReady); end
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", WriteEnable); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", Busy); end
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", Done); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", Overflow); end
    n_vec++; if (ChecksumError !== 1'b0) begin n_err++; $display("FAIL rst_cerr got %b want 0", ChecksumError); end
    n_vec++; if (WriteAddress !== 4'd0) begin n_err++; $display("FAIL rst_addr got %h want 0", WriteAddress); end
    n_vec++; if (WriteDataLow !== 16'h0000) begin n_err++; $display("FAIL rst_lo got %h want 0000", WriteDataLow); end
    n_vec++; if (WriteDataHigh !== 16'h0000) begin n_err++; $display("FAIL rst_hi got %h want 0000", WriteDataHigh); end
    tick;
  endtask

  task automatic run_two_words(input string name, input bit stall);
    logic [7:0] b[$];
    int n;
    b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_logs;
    start_load(5'd2);
    send_stream(b, stall, 60, n);
    finish_load(cks_of(b));
    wait_done(name);
    @(negedge CLK);
    n_vec++; if (n !== 8) begin n_err++; $display("FAIL %s_accepted got %0d want 8", name, n); end
    n_vec++; if (wa_log.size() !== 2) begin n_err++; $display("FAIL %s_nwrites got %0d want 2", name, wa_log.size()); end
    if (wa_log.size() == 2 && ac_log.size() >= 8) begin
      n_vec++; if (wa_log[0] !== 4'd0) begin n_err++; $display("FAIL %s_addr0 got %h want 0", name, wa_log[0]); end
      n_vec++; if (wl_log[0] !== 16'h5678) begin n_err++; $display("FAIL %s_lo0 got %h want 5678", name, wl_log[0]); end
      n_vec++; if (wh_log[0] !== 16'h1234) begin n_err++; $display("FAIL %s_hi0 got %h want 1234", name, wh_log[0]); end
      n_vec++; if (wa_log[1] !== 4'd1) begin n_err++; $display("FAIL %s_addr1 got %h want 1", name, wa_log[1]); end
      n_vec++; if (wl_log[1] !== 16'hBEEF) begin n_err++; $display("FAIL %s_lo1 got %h want BEEF", name, wl_log[1]); end
      n_vec++; if (wh_log[1] !== 16'hDEAD) begin n_err++; $display("FAIL %s_hi1 got %h want DEAD", name, wh_log[1]); end
      n_vec++; if (wc_log[0] !== ac_log[3] + 1) begin n_err++; $display("FAIL %s_lat0 got %0d want %0d", name, wc_log[0], ac_log[3] + 1); end
      n_vec++; if (wc_log[1] !== ac_log[7] + 1) begin n_err++; $display("FAIL %s_lat1 got %0d want %0d", name, wc_log[1], ac_log[7] + 1); end
    end
    n_vec++; if (rdy_in_write !== 0) begin n_err++; $display("FAIL %s_ready_in_write got %0d want 0", name, rdy_in_write); end
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL %s_done got %b want 1", name, Done); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL %s_busy got %b want 0", name, Busy); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL %s_ovf got %b want 0", name, Overflow); end
    n_vec++; if (ChecksumError !== 1'b0) begin n_err++; $display("FAIL %s_cerr got %b want 0", name, ChecksumError); end
    tick;
  endtask

  task automatic test_basic;
    do_reset;
    run_two_words("basic", 1'b0);
  endtask

  task automatic test_stall;
    run_two_words("stall", 1'b1);
  endtask

  task automatic test_overflow;
    logic [7:0] b[$];
    int n;
    int exp_n;
    for (int i = 0; i < 80; i++) b.push_back(8'(i));
    clear_logs;
    start_load(5'd20);
    send_stream(b, 1'b0, 200, n);
    wait_done("ovf");
    @(negedge CLK);
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    exp_n = 65;  // byte 64 is consumed as the checksum
    // sum(0..63)=0xE0, plus checksum 0x40 = 0x20 -> mismatch
    n_vec++; if (ChecksumError !== 1'b1) begin n_err++; $display("FAIL ovf_cerr got %b want 1", ChecksumError); end
`else
    exp_n = 64;
`endif
    n_vec++; if (n !== exp_n) begin n_err++; $display("FAIL ovf_accepted got %0d want %0d", n, exp_n); end
    n_vec++; if (wa_log.size() !== 16) begin n_err++; $display("FAIL ovf_nwrites got %0d want 16", wa_log.size()); end
    for (int j = 0; j < 16 && j < wa_log.size(); j++) begin
      logic [15:0] el;
      logic [15:0] eh;
      el = {8'(4 * j + 1), 8'(4 * j)};
      eh = {8'(4 * j + 3), 8'(4 * j + 2)};
      n_vec++; if (wa_log[j] !== 4'(j)) begin n_err++; $display("FAIL ovf_addr%0d got %h want %h", j, wa_log[j], 4'(j)); end
      n_vec++; if (wl_log[j] !== el) begin n_err++; $display("FAIL ovf_lo%0d got %h want %h", j, wl_log[j], el); end
      n_vec++; if (wh_log[j] !== eh) begin n_err++; $display("FAIL ovf_hi%0d got %h want %h", j, wh_log[j], eh); end
    end
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL ovf_done got %b want 1", Done); end
    n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", Overflow); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy got %b want 0", Busy); end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [7:0] b[$];
    logic [7:0] b2[$];
    int n;
    b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    b2 = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs;
    start_load(5'd3);
    send_stream(b, 1'b0, 30, n);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    @(negedge CLK);
    n_vec++; if (wa_log.size() !== 1) begin n_err++; $display("FAIL mid_nwrites got %0d want 1", wa_log.size()); end
    if (wa_log.size() == 1) begin
      n_vec++; if (wa_log[0] !== 4'd0) begin n_err++; $display("FAIL mid_addr0 got %h want 0", wa_log[0]); end
      n_vec++; if (wl_log[0] !== 16'hA1A0) begin n_err++; $display("FAIL mid_lo0 got %h want A1A0", wl_log[0]); end
      n_vec++; if (wh_log[0] !== 16'hA3A2) begin n_err++; $display("FAIL mid_hi0 got %h want A3A2", wh_log[0]); end
    end
    n_vec++; if (ByteReady !== 1'b0) begin n_err++; $display("FAIL mid_ready got %b want 0", ByteReady); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", Busy); end
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL mid_done got %b want 0", Done); end
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL mid_we got %b want 0", WriteEnable); end
    n_vec++; if (WriteAddress !== 4'd0) begin n_err++; $display("FAIL mid_addr got %h want 0", WriteAddress); end
    n_vec++; if (WriteDataLow !== 16'h0000) begin n_err++; $display("FAIL mid_lo got %h want 0000", WriteDataLow); end
    n_vec++; if (WriteDataHigh !== 16'h0000) begin n_err++; $display("FAIL mid_hi got %h want 0000", WriteDataHigh); end
    tick;
    clear_logs;
    start_load(5'd1);
    send_stream(b2, 1'b0, 20, n);
    finish_load(cks_of(b2));
    wait_done("mid_fresh");
    @(negedge CLK);
    n_vec++; if (wa_log.size() !== 1) begin n_err++; $display("FAIL fresh_nwrites got %0d want 1", wa_log.size()); end
    if (wa_log.size() == 1) begin
      n_vec++; if (wa_log[0] !== 4'd0) begin n_err++; $display("FAIL fresh_addr got %h want 0", wa_log[0]); end
      n_vec++; if (wl_log[0] !== 16'h2211) begin n_err++; $display("FAIL fresh_lo got %h want 2211", wl_log[0]); end
      n_vec++; if (wh_log[0] !== 16'h4433) begin n_err++; $display("FAIL fresh_hi got %h want 4433", wh_log[0]); end
    end
    tick;
  endtask

  task automatic test_zero_start;
    logic [7:0] b[$];
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    int n;
    b  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    pa = '{8'hC1, 8'hC2};
    pb = '{8'hC3, 8'hC4};
    do_reset;
    clear_logs;
    @(negedge CLK);
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL zero_pre_done got %b want 0", Done); end
    tick;
    start_load(5'd0);
    @(negedge CLK);
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    n_vec++; if (ByteReady !== 1'b1) begin n_err++; $display("FAIL zero_check_ready got %b want 1", ByteReady); end
    tick;
    finish_load(8'h00);
    wait_done("zero");
    @(negedge CLK);
    n_vec++; if (ChecksumError !== 1'b0) begin n_err++; $display("FAIL zero_cerr got %b want 0", ChecksumError); end
`endif
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", Done); end
    n_vec++; if (wa_log.size() !== 0) begin n_err++; $display("FAIL zero_nwrites got %0d want 0", wa_log.size()); end
    tick;
    clear_logs;
    start_load(5'd1);
    send_stream(pa, 1'b0, 20, n);
    start_load(5'd5);
    @(negedge CLK);
    n_vec++; if (Busy !== 1'b1) begin n_err++; $display("FAIL ign_busy got %b want 1", Busy); end
    tick;
    send_stream(pb, 1'b0, 20, n);
    finish_load(cks_of(b));
    wait_done("ign");
    @(negedge CLK);
    n_vec++; if (wa_log.size() !== 1) begin n_err++; $display("FAIL ign_nwrites got %0d want 1", wa_log.size()); end
    if (wa_log.size() == 1) begin
      n_vec++; if (wl_log[0] !== 16'hC2C1) begin n_err++; $display("FAIL ign_lo got %h want C2C1", wl_log[0]); end
      n_vec++; if (wh_log[0] !== 16'hC4C3) begin n_err++; $display("FAIL ign_hi got %h want C4C3", wh_log[0]); end
    end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL ign_ovf got %b want 0", Overflow); end
    tick;
  endtask

`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] b[$];
    int n;
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    clear_logs;
    start_load(5'd1);
    send_stream(b, 1'b0, 20, n);
    finish_load(8'hF6);
    wait_done("ck_pass");
    @(negedge CLK);
    n_vec++; if (ChecksumError !== 1'b0) begin n_err++; $display("FAIL ck_pass_cerr got %b want 0", ChecksumError); end
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL ck_pass_done got %b want 1", Done); end
    tick;
    clear_logs;
    start_load(5'd1);
    send_stream(b, 1'b0, 20, n);
    finish_load(8'hF5);
    wait_done("ck_fail");
    @(negedge CLK);
    n_vec++; if (ChecksumError !== 1'b1) begin n_err++; $display("FAIL ck_fail_cerr got %b want 1", ChecksumError); end
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL ck_fail_done got %b want 1", Done); end
    n_vec++; if (wa_log.size() !== 1) begin n_err++; $display("FAIL ck_fail_nwrites got %0d want 1", wa_log.size()); end
    if (wa_log.size() == 1) begin
      n_vec++; if (wa_log[0] !== 4'd0) begin n_err++; $display("FAIL ck_fail_addr got %h want 0", wa_log[0]); end
      n_vec++; if (wl_log[0] !== 16'h0201) begin n_err++; $display("FAIL ck_fail_lo got %h want 0201", wl_log[0]); end
      n_vec++; if (wh_log[0] !== 16'h0403) begin n_err++; $display("FAIL ck_fail_hi got %h want 0403", wh_log[0]); end
    end
    tick;
  endtask
`endif

  initial begin
    RST = 1'b1; Start = 1'b0; NumWords = '0; ByteIn = 8'h00; ByteValid = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_overflow;
    test_reset_mid;
    test_zero_start;
`ifdef PROGRAM_ROM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
